// File: rtl/background_scheduler.sv
// rtl/background_scheduler.sv - frame-synchronous background/color/time scheduler
//
// Purpose: accepts register writes into a shadow bank and commits them to the
// active outputs once per frame (on frame_start). The cycle after the commit
// it advances the animation time and the background auto-cycle offset.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   frame_start  one-cycle pulse at the start of vertical blanking
//   wr_valid     register write request
//   wr_ready     write accept (low only during COMMIT)
//   wr_addr      register address (0 ctrl, 1-4 colors, 5 cycle_period, 6 time_load, 7 none)
//   wr_data      register write data
//   bg_select    (active base_sel + bg_off) mod 4
//   cur_time     animation time
//   color1..4    active user colors

module background_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [1:0] bg_select,
  output logic [7:0] cur_time,
  output logic [5:0] color1,
  output logic [5:0] color2,
  output logic [5:0] color3,
  output logic [5:0] color4
);

  localparam logic [7:0] CTRL_RST   = 8'h00;
  localparam logic [5:0] COLOR1_RST = 6'h00;
  localparam logic [5:0] COLOR2_RST = 6'h15;
  localparam logic [5:0] COLOR3_RST = 6'h2A;
  localparam logic [5:0] COLOR4_RST = 6'h3F;
  localparam logic [7:0] PERIOD_RST = 8'd59;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMMIT  = 2'd1,
    S_ADVANCE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic       commit_en;
  logic       advance_en;
  logic       wr_fire;

  // Shadow bank (written by the register port)
  logic [7:0] sh_ctrl;
  logic [5:0] sh_color1, sh_color2, sh_color3, sh_color4;
  logic [7:0] sh_cycle_period;

  // Active bank (loaded in COMMIT)
  logic [7:0] act_ctrl;
  logic [7:0] act_cycle_period;

  logic [3:0] div_cnt;
  logic [7:0] cyc_cnt;
  logic [1:0] bg_off;
  logic       load_pending;
  logic [7:0] load_val;

  logic [1:0] base_sel;
  logic       pause;
  logic       auto_cycle;
  logic [3:0] speed;

  assign base_sel   = act_ctrl[1:0];
  assign pause      = act_ctrl[2];
  assign auto_cycle = act_ctrl[3];
  assign speed      = act_ctrl[7:4];

  assign wr_fire = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; frame_start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (frame_start) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    wr_ready   = 1'b1;
    commit_en  = 1'b0;
    advance_en = 1'b0;
    case (state)
      S_COMMIT:  begin wr_ready = 1'b0; commit_en = 1'b1; end
      S_ADVANCE: advance_en = 1'b1;
      default:   ;
    endcase
  end

  // Shadow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_ctrl         <= CTRL_RST;
      sh_color1       <= COLOR1_RST;
      sh_color2       <= COLOR2_RST;
      sh_color3       <= COLOR3_RST;
      sh_color4       <= COLOR4_RST;
      sh_cycle_period <= PERIOD_RST;
    end else if (wr_fire) begin
      case (wr_addr)
        3'd0: sh_ctrl         <= wr_data;
        3'd1: sh_color1       <= wr_data[5:0];
        3'd2: sh_color2       <= wr_data[5:0];
        3'd3: sh_color3       <= wr_data[5:0];
        3'd4: sh_color4       <= wr_data[5:0];
        3'd5: sh_cycle_period <= wr_data;
        default: ;
      endcase
    end
  end

  // Time load request; a new write in ADVANCE re-arms it after the old value is consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_pending <= 1'b0;
      load_val     <= 8'h00;
    end else if (wr_fire && wr_addr == 3'd6) begin
      load_pending <= 1'b1;
      load_val     <= wr_data;
    end else if (advance_en) begin
      load_pending <= 1'b0;
    end
  end

  // Active registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_ctrl         <= CTRL_RST;
      color1           <= COLOR1_RST;
      color2           <= COLOR2_RST;
      color3           <= COLOR3_RST;
      color4           <= COLOR4_RST;
      act_cycle_period <= PERIOD_RST;
    end else if (commit_en) begin
      act_ctrl         <= sh_ctrl;
      color1           <= sh_color1;
      color2           <= sh_color2;
      color3           <= sh_color3;
      color4           <= sh_color4;
      act_cycle_period <= sh_cycle_period;
    end
  end

  // Animation time: load beats pause, pause beats the speed divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_time <= 8'h00;
      div_cnt  <= 4'd0;
    end else if (advance_en) begin
      if (load_pending) begin
        cur_time <= load_val;
        div_cnt  <= 4'd0;
      end else if (!pause) begin
        if (div_cnt == speed) begin
          div_cnt  <= 4'd0;
          cur_time <= cur_time + 8'd1;
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end
    end
  end

  // Background auto-cycle offset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= 8'd0;
      bg_off  <= 2'd0;
    end else if (advance_en) begin
      if (!auto_cycle) begin
        cyc_cnt <= 8'd0;
        bg_off  <= 2'd0;
      end else if (cyc_cnt == act_cycle_period) begin
        cyc_cnt <= 8'd0;
        bg_off  <= bg_off + 2'd1;
      end else begin
        cyc_cnt <= cyc_cnt + 8'd1;
      end
    end
  end

  // 2-bit add wraps mod 4
  assign bg_select = base_sel + bg_off;

endmodule

// File: tb/tb_background_scheduler.sv
// tb/tb_background_scheduler.sv - self-checking bench for background_scheduler

module tb_background_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] bg_select;
  logic [7:0] cur_time;
  logic [5:0] color1, color2, color3, color4;

  background_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .bg_select   (bg_select),
    .cur_time    (cur_time),
    .color1      (color1),
    .color2      (color2),
    .color3      (color3),
    .color4      (color4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic       do_frame;
    logic [1:0] exp_bg;
    logic [7:0] exp_time;
    logic [5:0] exp_c1;
    logic [5:0] exp_c3;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];
  vec_t exp_q [$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [7:0] d,
                              input logic f, input logic [1:0] bg, input logic [7:0] t,
                              input logic [5:0] c1, input logic [5:0] c3);
    vec_t v;
    v.do_wr = w; v.addr = a; v.data = d; v.do_frame = f;
    v.exp_bg = bg; v.exp_time = t; v.exp_c1 = c1; v.exp_c3 = c3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    while (!wr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check("write_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  // frame_start at edge N, returns at the negedge after edge N+2
  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bg_select"}, bg_select, 2'd0);
    check({tag, "_cur_time"}, cur_time, 8'h00);
    check({tag, "_color1"}, color1, 6'h00);
    check({tag, "_color2"}, color2, 6'h15);
    check({tag, "_color3"}, color3, 6'h2A);
    check({tag, "_color4"}, color4, 6'h3F);
    check({tag, "_wr_ready"}, wr_ready, 1'b1);
  endtask

  initial begin
    vec_t e;
    // write?, addr, data, frame?, bg, time, color1, color3
    vecs[0]  = mk(1, 3'd0, 8'h20, 0, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[1]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[2]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[3]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h01, 6'h00, 6'h2A);
    vecs[4]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h01, 6'h00, 6'h2A);
    vecs[5]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h01, 6'h00, 6'h2A);
    vecs[6]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h02, 6'h00, 6'h2A);
    vecs[7]  = mk(1, 3'd6, 8'hFF, 0, 2'd0, 8'h02, 6'h00, 6'h2A);
    vecs[8]  = mk(1, 3'd0, 8'h00, 0, 2'd0, 8'h02, 6'h00, 6'h2A);
    vecs[9]  = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'hFF, 6'h00, 6'h2A);
    vecs[10] = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[11] = mk(1, 3'd0, 8'h0B, 0, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[12] = mk(1, 3'd5, 8'h00, 0, 2'd0, 8'h00, 6'h00, 6'h2A);
    vecs[13] = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h01, 6'h00, 6'h2A);
    vecs[14] = mk(0, 3'd0, 8'h00, 1, 2'd1, 8'h02, 6'h00, 6'h2A);
    vecs[15] = mk(0, 3'd0, 8'h00, 1, 2'd2, 8'h03, 6'h00, 6'h2A);
    vecs[16] = mk(0, 3'd0, 8'h00, 1, 2'd3, 8'h04, 6'h00, 6'h2A);
    vecs[17] = mk(1, 3'd0, 8'h03, 0, 2'd3, 8'h04, 6'h00, 6'h2A);
    vecs[18] = mk(0, 3'd0, 8'h00, 1, 2'd3, 8'h05, 6'h00, 6'h2A);
    vecs[19] = mk(1, 3'd0, 8'h04, 0, 2'd3, 8'h05, 6'h00, 6'h2A);
    vecs[20] = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h05, 6'h00, 6'h2A);
    vecs[21] = mk(1, 3'd1, 8'h3A, 1, 2'd0, 8'h05, 6'h3A, 6'h2A);
    vecs[22] = mk(1, 3'd6, 8'h80, 0, 2'd0, 8'h05, 6'h3A, 6'h2A);
    vecs[23] = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h80, 6'h3A, 6'h2A);
    vecs[24] = mk(0, 3'd0, 8'h00, 1, 2'd0, 8'h80, 6'h3A, 6'h2A);
    vecs[25] = mk(1, 3'd7, 8'hAA, 1, 2'd0, 8'h80, 6'h3A, 6'h2A);
    vecs[26] = mk(1, 3'd0, 8'h00, 1, 2'd0, 8'h81, 6'h3A, 6'h2A);

    // Reset values
    repeat (2) @(negedge clk);
    check("during_reset_wr_ready", wr_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Shadowing: write lands in shadow only; visible after the COMMIT edge
    do_write(3'd3, 8'h11);
    @(negedge clk);
    check("shadow_color3_idle", color3, 6'h2A);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    check("commit_color3_old", color3, 6'h2A);
    check("commit_wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    check("advance_color3_new", color3, 6'h11);
    check("advance_time_old", cur_time, 8'h00);
    check("advance_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    check("idle_time_new", cur_time, 8'h01);

    // Table-driven frames with scoreboard
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].data);
      if (vecs[i].do_frame) do_frame();
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d_bg_select", i), bg_select, e.exp_bg);
        check($sformatf("vec%0d_cur_time", i), cur_time, e.exp_time);
        check($sformatf("vec%0d_color1", i), color1, e.exp_c1);
        check($sformatf("vec%0d_color3", i), color3, e.exp_c3);
      end
    end

    // Handshake: write+frame same cycle, write held through COMMIT, frame_start held into ADVANCE
    do_write(3'd6, 8'h10);
    @(negedge clk);
    frame_start = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h05;
    @(posedge clk);
    #1 wr_addr = 3'd6; wr_data = 8'h20;
    @(negedge clk);
    check("hs_commit_wr_ready", wr_ready, 1'b0);
    check("hs_commit_color2_old", color2, 6'h15);
    @(negedge clk);
    check("hs_advance_wr_ready", wr_ready, 1'b1);
    check("hs_same_cycle_color2", color2, 6'h05);
    check("hs_advance_time_old", cur_time, 8'h81);
    @(posedge clk);
    #1 wr_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    check("hs_load_time", cur_time, 8'h10);
    check("hs_no_second_commit", wr_ready, 1'b1);
    @(negedge clk);
    check("hs_no_second_commit2", wr_ready, 1'b1);
    check("hs_time_stable", cur_time, 8'h10);
    do_frame();
    check("hs_set_wins_load", cur_time, 8'h20);

    // Reset mid-ADVANCE discards everything
    do_write(3'd0, 8'h02);
    do_write(3'd4, 8'h01);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_bg_select", bg_select, 2'd2);
    check("pre_reset_color4", color4, 6'h01);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midadv_reset");
    reset = 1'b0;
    do_frame();
    check("post_reset_time", cur_time, 8'h01);
    check("post_reset_color4", color4, 6'h3F);
    check("post_reset_bg", bg_select, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/background_scheduler.md
BACKGROUND_SCHEDULER -- requirements
Module: background_scheduler

Interface
REQ-001 Parameters: none; all configuration is held in registers.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 frame_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-005 wr_valid  input  1  register write request.
REQ-006 wr_ready  output  1  write accept; a write transfers when wr_valid && wr_ready.
REQ-007 wr_addr  input  3  register address.
REQ-008 wr_data  input  8  register write data.
REQ-009 bg_select  output  2  background selection sent to the background generator.
REQ-010 cur_time  output  8  animation time.
REQ-011 color1..color4  output  6 each  active user colors.

Function
REQ-012 Shadow register map:
- 0 ctrl: [1:0] base_sel, [2] pause, [3] auto_cycle, [7:4] speed.
- 1-4: color1-color4, using wr_data[5:0].
- 5: cycle_period.
- 6: time_load; stores load_val and sets load_pending.
- 7: writes ignored.
REQ-013 Writes in any accepting cycle update only the shadow registers; the active outputs never change on a write.
REQ-014 State machine: IDLE -> COMMIT when frame_start=1; COMMIT -> ADVANCE unconditionally; ADVANCE -> IDLE unconditionally.
REQ-015 frame_start is ignored in COMMIT and ADVANCE.
REQ-016 wr_ready = 0 only in COMMIT; it is 1 in IDLE, in ADVANCE and during reset.
REQ-017 COMMIT cycle copies shadow ctrl, colors and cycle_period into the active registers.
REQ-018 Timing, with frame_start sampled at edge N:
- colors and base_sel are visible from cycle N+2;
- cur_time and the bg_select offset update at the end of ADVANCE and are visible from cycle N+3.
REQ-019 ADVANCE, time, load case: if load_pending=1, then cur_time=load_val, div_cnt=0 and load_pending is cleared.
- This case overrides pause and speed.
REQ-020 ADVANCE, time, pause case: otherwise, if pause=1, cur_time and div_cnt hold.
REQ-021 ADVANCE, time, normal case: otherwise, if div_cnt==speed then div_cnt=0 and cur_time+=1 (mod 256, 0xFF->0x00); else div_cnt+=1.
REQ-022 A time_load write accepted in the ADVANCE cycle leaves load_pending=1 with the new load_val (set wins over clear).
REQ-023 ADVANCE, auto-cycle enabled: if auto_cycle=1 and cyc_cnt==cycle_period, then cyc_cnt=0 and bg_off+=1 (mod 4); else cyc_cnt+=1.
REQ-024 ADVANCE, auto-cycle disabled: if auto_cycle=0, then bg_off=0 and cyc_cnt=0.
REQ-025 bg_select = (active base_sel + bg_off) mod 4, computed from registered values only.
REQ-026 A write and a frame_start in the same IDLE cycle: the write lands in shadow, COMMIT copies the post-write shadow value, and it is visible at N+2.

Reset
REQ-027 Reset sets: state=IDLE, wr_ready=1, bg_select=0, cur_time=0x00.
REQ-028 Reset sets the shadow and active registers: ctrl=0x00, color1=0x00, color2=0x15, color3=0x2A, color4=0x3F, cycle_period=59.
REQ-029 Reset sets div_cnt=0, cyc_cnt=0, bg_off=0, load_pending=0, load_val=0.
REQ-030 Reset asserted in any state, including mid-COMMIT or mid-ADVANCE, immediately forces the REQ-027 to REQ-029 values; no partial commit survives.

Verification
REQ-031 The bench shall cover these directed scenarios:
- Reset: assert reset, release -> bg_select=0, cur_time=0, colors 0x00/0x15/0x2A/0x3F, wr_ready=1; reassert mid-ADVANCE -> same values next cycle.
- Shadowing: write addr3=0x11 in IDLE -> color3 stays 0x2A; frame_start at edge N -> color3=0x11 from N+2.
- Speed: write ctrl=0x20, then 6 frame_start pulses -> cur_time=0x02.
- Load and wrap: write addr6=0xFF, ctrl=0x00, frame -> cur_time=0xFF; next frame -> 0x00.
- Auto-cycle: ctrl=0x0B, cycle_period=0, frames 1-4 -> bg_select 0,1,2,3; then write ctrl=0x03, frame -> bg_select=3.
- Handshake: wr_valid held during COMMIT -> wr_ready=0, accepted the next cycle; frame_start in ADVANCE -> ignored, no second COMMIT.
